// File: rtl/mem_ctrl.sv
// mem_ctrl: single-port SRAM access controller with programmable wait states.
//   Parameters: WAIT_STATES (0..15) extra access cycles; PROT_LIMIT first writable
//   address (only with MEM_PROTECT_EN).
//   Macro MEM_PROTECT_EN: when defined, writes below PROT_LIMIT are blocked and
//   reported on ACCESS_VIOLATION.
//   Ports: CLK/RESET (async, active-high); MAR_LE, MAR_CONTROL, MEM_WE, EA, PC,
//   WDATA request side; MAR, MDR, MEM_BUSY, MEM_READY status side; SRAM_ADDR,
//   SRAM_WDATA, SRAM_RDATA, SRAM_CE, SRAM_WE SRAM side; ACCESS_VIOLATION fault pulse.
module mem_ctrl #(
    parameter int WAIT_STATES = 2
`ifdef MEM_PROTECT_EN
    , parameter logic [15:0] PROT_LIMIT = 16'h3000
`endif
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MAR_LE,
    input  logic        MAR_CONTROL,
    input  logic        MEM_WE,
    input  logic [15:0] EA,
    input  logic [15:0] PC,
    input  logic [15:0] WDATA,
    output logic [15:0] MAR,
    output logic [15:0] MDR,
    output logic        MEM_BUSY,
    output logic        MEM_READY,
    output logic [15:0] SRAM_ADDR,
    output logic [15:0] SRAM_WDATA,
    input  logic [15:0] SRAM_RDATA,
    output logic        SRAM_CE,
`ifdef MEM_PROTECT_EN
    output logic        SRAM_WE,
    output logic        ACCESS_VIOLATION
`else
    output logic        SRAM_WE
`endif
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t      r_state, w_next;
    logic [15:0] r_mar, r_mdr, r_wdata;
    logic        r_we;
    logic [3:0]  r_cnt;
    logic        w_blk;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= IDLE;
            r_mar   <= 16'h0000;
            r_mdr   <= 16'h0000;
            r_wdata <= 16'h0000;
            r_we    <= 1'b0;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && MAR_LE) begin
                r_mar   <= MAR_CONTROL ? PC : EA;
                r_we    <= MEM_WE;
                r_wdata <= WDATA;
                r_cnt   <= 4'(WAIT_STATES);
            end
            // Counter saturates at 0; the zero cycle is the last ACCESS cycle and captures read data.
            if (r_state == ACCESS) begin
                if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
                else if (!r_we) r_mdr <= SRAM_RDATA;
            end
        end
    end

    always_comb begin
        w_next = IDLE;
        w_next = r_state == IDLE   ? (MAR_LE ? ACCESS : IDLE) :
                 r_state == ACCESS ? (r_cnt == 4'd0 ? DONE : ACCESS) : IDLE;
    end

`ifdef MEM_PROTECT_EN
    assign w_blk            = r_we && (r_mar < PROT_LIMIT);
    assign ACCESS_VIOLATION = (r_state == DONE) && w_blk;
`else
    assign w_blk = 1'b0;
`endif

    assign MAR        = r_mar;
    assign MDR        = r_mdr;
    assign SRAM_ADDR  = r_mar;
    assign SRAM_WDATA = r_wdata;
    assign MEM_BUSY   = r_state != IDLE;
    assign MEM_READY  = r_state == DONE;
    assign SRAM_CE    = (r_state == ACCESS) && !w_blk;
    assign SRAM_WE    = (r_state == ACCESS) && r_we && !w_blk;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed table-driven bench for mem_ctrl with WAIT_STATES 0 and 2 side by side.
module tb_mem_ctrl;
`ifdef MEM_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif
    logic        CLK = 1'b0;
    logic        RESET, MAR_LE, MAR_CONTROL, MEM_WE;
    logic [15:0] EA, PC, WDATA, SRAM_RDATA;
    logic [15:0] mar [2], mdr [2], sa_o [2], sw_o [2];
    logic        busy [2], rdy [2], ce [2], we_o [2], viol [2];
    int          nchk = 0, nerr = 0;

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_ctrl #(.WAIT_STATES(2 * g)) u_dut (
            .CLK(CLK), .RESET(RESET), .MAR_LE(MAR_LE), .MAR_CONTROL(MAR_CONTROL),
            .MEM_WE(MEM_WE), .EA(EA), .PC(PC), .WDATA(WDATA),
            .MAR(mar[g]), .MDR(mdr[g]), .MEM_BUSY(busy[g]), .MEM_READY(rdy[g]),
            .SRAM_ADDR(sa_o[g]), .SRAM_WDATA(sw_o[g]), .SRAM_RDATA(SRAM_RDATA),
`ifdef MEM_PROTECT_EN
            .SRAM_CE(ce[g]), .SRAM_WE(we_o[g]), .ACCESS_VIOLATION(viol[g])
`else
            .SRAM_CE(ce[g]), .SRAM_WE(we_o[g])
`endif
        );
`ifndef MEM_PROTECT_EN
        assign viol[g] = 1'b0;
`endif
    end

    typedef struct {
        logic        we, ctl, scr;
        logic [15:0] ea, pc, wd, rd, mar, mdr;
        logic        blk;
    } vec_t;
    vec_t v [6];

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s dut%0d: got %h expected %h", name, d, act, exp);
        end
    endtask

    int          ce_n [2], we_n [2], rdy_n [2], rdy_at [2], viol_n [2], viol_t [2];
    logic [15:0] sa [2], sw [2];
    logic [5:0]  pat [2];

    initial begin
        v[0] = '{1'b0, 1'b1, 1'b0, 16'h1111, 16'h3000, 16'h0000, 16'h1234, 16'h3000, 16'h1234, 1'b0};
        v[1] = '{1'b1, 1'b0, 1'b0, 16'h4000, 16'h7777, 16'hBEEF, 16'h9999, 16'h4000, 16'h1234, 1'b0};
        v[2] = '{1'b0, 1'b0, 1'b1, 16'h0ABC, 16'hFFFF, 16'h1357, 16'h5A5A, 16'h0ABC, 16'h5A5A, 1'b0};
        v[3] = '{1'b1, 1'b1, 1'b1, 16'h2222, 16'h8001, 16'h0F0F, 16'h6666, 16'h8001, 16'h5A5A, 1'b0};
        v[4] = '{1'b1, 1'b0, 1'b0, 16'h2FFF, 16'h0000, 16'hCAFE, 16'h1111, 16'h2FFF, 16'h5A5A, PROT};
        v[5] = '{1'b1, 1'b0, 1'b0, 16'h3000, 16'h0000, 16'hF00D, 16'h2222, 16'h3000, 16'h5A5A, 1'b0};

        RESET = 1'b1; MAR_LE = 1'b0; MAR_CONTROL = 1'b0; MEM_WE = 1'b0;
        EA = 16'hAAAA; PC = 16'hBBBB; WDATA = 16'hCCCC; SRAM_RDATA = 16'hDDDD;
        repeat (2) @(negedge CLK);
        for (int d = 0; d < 2; d++) begin
            check("rst_busy", d, 32'(busy[d]), 0);
            check("rst_ready", d, 32'(rdy[d]), 0);
            check("rst_ce", d, 32'(ce[d]), 0);
            check("rst_we", d, 32'(we_o[d]), 0);
            check("rst_viol", d, 32'(viol[d]), 0);
            check("rst_mar", d, 32'(mar[d]), 0);
            check("rst_mdr", d, 32'(mdr[d]), 0);
            check("rst_wdata", d, 32'(sw_o[d]), 0);
        end
        RESET = 1'b0;

        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            MEM_WE = v[i].we; MAR_CONTROL = v[i].ctl; EA = v[i].ea; PC = v[i].pc;
            WDATA = v[i].wd; SRAM_RDATA = v[i].rd; MAR_LE = 1'b1;
            for (int d = 0; d < 2; d++) begin
                ce_n[d] = 0; we_n[d] = 0; rdy_n[d] = 0; rdy_at[d] = 0; viol_n[d] = 0; viol_t[d] = 0;
            end
            @(negedge CLK);
            MAR_LE = 1'b0;
            for (int n = 1; n <= 8; n++) begin
                for (int d = 0; d < 2; d++) begin
                    ce_n[d] += int'(ce[d]);
                    we_n[d] += int'(we_o[d]);
                    viol_t[d] += int'(viol[d]);
                    viol_n[d] += int'(viol[d] && rdy[d]);
                    if (rdy[d]) begin
                        rdy_n[d]++;
                        rdy_at[d] = n;
                    end
                    if (n == 1) begin
                        sa[d] = sa_o[d];
                        sw[d] = sw_o[d];
                    end
                end
                if (v[i].scr && n == 1) begin
                    EA = 16'h5555; PC = ~PC; WDATA = ~WDATA; MEM_WE = ~MEM_WE;
                    MAR_CONTROL = ~MAR_CONTROL; MAR_LE = 1'b1;
                end
                if (n == 2) MAR_LE = 1'b0;
                @(negedge CLK);
            end
            for (int d = 0; d < 2; d++) begin
                check($sformatf("v%0d_mar", i), d, 32'(mar[d]), 32'(v[i].mar));
                check($sformatf("v%0d_mdr", i), d, 32'(mdr[d]), 32'(v[i].mdr));
                check($sformatf("v%0d_ready_count", i), d, rdy_n[d], 1);
                check($sformatf("v%0d_ready_cycle", i), d, rdy_at[d], 2 * d + 2);
                check($sformatf("v%0d_ce_cycles", i), d, ce_n[d], v[i].blk ? 0 : 2 * d + 1);
                check($sformatf("v%0d_we_cycles", i), d, we_n[d], (v[i].we && !v[i].blk) ? 2 * d + 1 : 0);
                check($sformatf("v%0d_viol_with_ready", i), d, viol_n[d], 32'(v[i].blk));
                check($sformatf("v%0d_viol_total", i), d, viol_t[d], 32'(v[i].blk));
                check($sformatf("v%0d_sram_addr", i), d, 32'(sa[d]), 32'(v[i].mar));
                check($sformatf("v%0d_sram_wdata", i), d, 32'(sw[d]), 32'(v[i].wd));
                check($sformatf("v%0d_idle_after", i), d, 32'(busy[d]), 0);
            end
        end

        // Reset in the second ACCESS cycle of a WAIT_STATES=2 read
        @(negedge CLK);
        MEM_WE = 1'b0; MAR_CONTROL = 1'b1; PC = 16'h1357; SRAM_RDATA = 16'hABCD; MAR_LE = 1'b1;
        @(negedge CLK);
        MAR_LE = 1'b0;
        check("abort_busy_before", 1, 32'(busy[1]), 1);
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        check("abort_busy", 1, 32'(busy[1]), 0);
        check("abort_ready", 1, 32'(rdy[1]), 0);
        check("abort_ce", 1, 32'(ce[1]), 0);
        check("abort_mdr", 1, 32'(mdr[1]), 0);
        check("abort_mar", 1, 32'(mar[1]), 0);
        @(negedge CLK);
        RESET = 1'b0; MAR_LE = 1'b1; MAR_CONTROL = 1'b0; EA = 16'h0246;
        @(negedge CLK);
        MAR_LE = 1'b0;
        check("post_reset_accept_busy", 1, 32'(busy[1]), 1);
        check("post_reset_accept_mar", 1, 32'(mar[1]), 32'h0246);
        rdy_n[1] = 0;
        for (int n = 0; n < 6; n++) begin
            rdy_n[1] += int'(rdy[1]);
            @(negedge CLK);
        end
        check("post_reset_ready_count", 1, rdy_n[1], 1);
        check("post_reset_mdr", 1, 32'(mdr[1]), 32'hABCD);

        // MAR_LE held high: the DONE->IDLE edge ignores it, the next IDLE edge accepts
        MEM_WE = 1'b0; MAR_CONTROL = 1'b0; EA = 16'h0100; MAR_LE = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge CLK);
            for (int d = 0; d < 2; d++) pat[d][n] = busy[d];
        end
        MAR_LE = 1'b0;
        check("held_le_busy_pattern", 0, 32'(pat[0]), 32'(6'b011011));
        check("held_le_busy_pattern", 1, 32'(pat[1]), 32'(6'b101111));
        repeat (8) @(negedge CLK);
        for (int d = 0; d < 2; d++) check("drain_idle", d, 32'(busy[d]), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter WAIT_STATES, default 2: extra SRAM access cycles per transaction; legal range 0..15.
REQ-002 Parameter PROT_LIMIT, default 16'h3000: first address writable when protection is compiled in.
REQ-003 Port CLK  input  1  sole clock; every register updates on its rising edge.
REQ-004 Port RESET  input  1  reset, asynchronous and active-high.
REQ-005 Port MAR_LE  input  1  request strobe from control; sampled only in IDLE.
REQ-006 Port MAR_CONTROL  input  1  address source: 0 = EA, 1 = PC.
REQ-007 Port MEM_WE  input  1  request type: 1 = write, 0 = read; sampled with MAR_LE.
REQ-008 Port EA  input  16  effective address.
REQ-009 Port PC  input  16  program counter, used for instruction fetch.
REQ-010 Port WDATA  input  16  store data; sampled with MAR_LE.
REQ-011 Port MAR  output  16  latched transaction address.
REQ-012 Port MDR  output  16  last read data.
REQ-013 Port MEM_BUSY  output  1  high while the state is not IDLE.
REQ-014 Port MEM_READY  output  1  one-cycle completion pulse.
REQ-015 Port SRAM_ADDR  output  16  SRAM address; equals MAR.
REQ-016 Port SRAM_WDATA  output  16  SRAM write data; equals the latched WDATA.
REQ-017 Port SRAM_RDATA  input  16  synchronous SRAM read data.
REQ-018 Port SRAM_CE  output  1  SRAM chip enable.
REQ-019 Port SRAM_WE  output  1  SRAM write enable.
REQ-020 Port ACCESS_VIOLATION  output  1  protection fault pulse; present only with MEM_PROTECT_EN.

Function
REQ-021 The block SHALL implement three states: IDLE, ACCESS and DONE.
REQ-022 IDLE with MAR_LE=1 at edge k SHALL do all of the following: latch MAR (PC if MAR_CONTROL=1, else EA); latch MEM_WE and WDATA; load the wait counter with WAIT_STATES; enter ACCESS.
REQ-023 ACCESS SHALL assert SRAM_CE, and SRAM_WE only for a permitted write, on every ACCESS cycle.
REQ-024 ACCESS SHALL decrement the wait counter each cycle, and SHALL move to DONE on the edge where the counter equals 0.
REQ-025 ACCESS SHALL therefore last WAIT_STATES+1 cycles, including when WAIT_STATES=0.
REQ-026 On the ACCESS-to-DONE edge of a read, MDR SHALL capture SRAM_RDATA; writes SHALL leave MDR unchanged.
REQ-027 DONE SHALL assert MEM_READY for exactly one cycle and SHALL always return to IDLE on the next edge.
REQ-028 MEM_READY SHALL be high in cycle k+WAIT_STATES+2 relative to the sampling edge k.
REQ-029 MAR_LE SHALL be ignored in ACCESS and DONE; no queueing.
REQ-030 MAR_LE on the edge that enters IDLE from DONE SHALL be ignored; it is sampled again on the next IDLE edge.
REQ-031 A changing EA, PC, WDATA or MEM_WE during a transaction SHALL NOT affect that transaction.
REQ-032 The wait counter SHALL be 4 bits and SHALL never wrap below 0.
REQ-033 MEM_BUSY SHALL be high exactly in ACCESS and DONE.

Reset
REQ-034 RESET=1 SHALL asynchronously force the following values: state IDLE; MAR, MDR and the latched WDATA = 16'h0000; wait counter = 0.
REQ-035 RESET=1 SHALL asynchronously force MEM_BUSY, MEM_READY, SRAM_CE, SRAM_WE and ACCESS_VIOLATION to 0.
REQ-036 Reset asserted mid-transaction SHALL abort it: no MEM_READY, and MDR reads 16'h0000.
REQ-037 After reset deasserts, the first MAR_LE SHALL be accepted on the first rising edge at which RESET is low.

Configuration
REQ-038 The macro MEM_PROTECT_EN SHALL control write protection.
REQ-039 With MEM_PROTECT_EN defined, a write with MAR < PROT_LIMIT SHALL keep SRAM_CE=0 and SRAM_WE=0 for the whole transaction.
REQ-040 With MEM_PROTECT_EN defined, a blocked write SHALL still follow the normal state timing, and ACCESS_VIOLATION SHALL pulse in the same cycle as MEM_READY.
REQ-041 With MEM_PROTECT_EN defined, reads SHALL never be blocked.
REQ-042 Without MEM_PROTECT_EN, the ACCESS_VIOLATION port and the comparison logic SHALL be absent, and all writes SHALL proceed.

Verification
REQ-043 Read with WAIT_STATES=2, MAR_CONTROL=1, PC=16'h3000, SRAM_RDATA=16'h1234 -> SRAM_CE high 3 cycles, MDR=16'h1234, MEM_READY in cycle k+4.
REQ-044 Write with WAIT_STATES=0, EA=16'h4000, WDATA=16'hBEEF -> SRAM_WE high 1 cycle, SRAM_ADDR=16'h4000, MEM_READY in cycle k+2, MDR unchanged.
REQ-045 Second MAR_LE pulse during ACCESS, EA=16'h5555 -> ignored, MAR retains the first address, exactly one MEM_READY.
REQ-046 RESET asserted in the second ACCESS cycle of a read -> MEM_BUSY, MEM_READY and SRAM_CE go low immediately and MDR=16'h0000.
REQ-047 MEM_PROTECT_EN defined, write EA=16'h2FFF -> SRAM_CE=0 and SRAM_WE=0 throughout, ACCESS_VIOLATION and MEM_READY high together.
REQ-048 MEM_PROTECT_EN defined, write EA=16'h3000 -> SRAM_WE asserted and ACCESS_VIOLATION stays 0.
